// File: rtl/mv_filter_gate_v4.sv
`default_nettype none
// ============================================================================
// Module   : mv_filter_gate_v4
// Brief    : Decimated moving-average filter over a 2^k sample window held in
//            a synchronous-read RAM. Optional macro MVF_ROUND_EN rounds half up.
// Revision : 1.0
// ============================================================================
module mv_filter_gate_v4 #(
  parameter int DW           = 32,
  parameter int LOG2_WIN_MAX = 13,
  parameter int DIV_FACTOR   = 4
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                trig,
  input  logic signed [DW-1:0]                din,
  input  logic [3:0]                          win_sel,
  input  logic                                restart,
  output logic signed [DW-1:0]                dout,
  output logic                                dout_vld,
  output logic                                busy,
  output logic                                filled,
  output logic signed [DW+LOG2_WIN_MAX-1:0]   sum_mon
);

  localparam int                    c_AW       = LOG2_WIN_MAX;
  localparam int                    c_SW       = DW + LOG2_WIN_MAX;
  localparam int                    c_DEPTH    = 1 << LOG2_WIN_MAX;
  localparam logic [3:0]            c_KMAX     = (LOG2_WIN_MAX > 15) ? 4'd15 : 4'(LOG2_WIN_MAX);
  localparam logic [5:0]            c_DIV_LAST = 6'(DIV_FACTOR - 1);
  localparam logic [c_AW-1:0]       c_A_ONE    = c_AW'(1);
  localparam logic [c_AW-1:0]       c_A_LAST   = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  logic [c_AW-1:0]         r_clr_addr;
  logic [c_AW-1:0]         r_idx;
  logic [c_AW-1:0]         r_a1;
  logic [3:0]              r_win_sel;
  logic [3:0]              r_k;
  logic [5:0]              r_div_cnt;
  logic                    r_v0;
  logic                    r_v1;
  logic                    r_fwd;
  logic signed [DW-1:0]    r_d0;
  logic signed [DW-1:0]    r_d1;
  logic signed [DW-1:0]    r_fwd_d;
  logic signed [DW-1:0]    r_rd_q;
  logic signed [c_SW-1:0]  r_sum;
  logic signed [DW-1:0]    r_mem [c_DEPTH];

  logic                    w_flush;
  logic                    w_we;
  logic [c_AW-1:0]         w_waddr;
  logic signed [DW-1:0]    w_wdata;
  logic [3:0]              w_k;
  logic [c_AW-1:0]         w_mask;
  logic [c_AW-1:0]         w_idx_next;
  logic signed [DW-1:0]    w_old;
  logic signed [c_SW-1:0]  w_sum_new;
  logic signed [c_SW-1:0]  w_pre;
  logic signed [DW-1:0]    w_dout;
  logic [c_SW-DW-1:0]      w_unused_hi;

  assign w_flush    = (r_state == ST_RUN) && (restart || (win_sel != r_win_sel));
  assign w_k        = (win_sel > c_KMAX) ? c_KMAX : win_sel;
  assign w_mask     = ~({c_AW{1'b1}} << r_k);
  assign w_idx_next = (r_idx == w_mask) ? '0 : (r_idx + c_A_ONE);

  // The slot read for this sample may be the one the previous sample is
  // writing on the same edge; r_fwd selects that in-flight value instead.
  assign w_old      = r_fwd ? r_fwd_d : r_rd_q;
  assign w_sum_new  = r_sum
                    - $signed({{LOG2_WIN_MAX{w_old[DW-1]}}, w_old})
                    + $signed({{LOG2_WIN_MAX{r_d1[DW-1]}}, r_d1});

`ifdef MVF_ROUND_EN
  logic signed [c_SW-1:0]  w_bias;
  assign w_bias = (r_k == 4'd0) ? '0 : $signed(c_SW'(1) << (r_k - 4'd1));
  assign w_pre  = w_sum_new + w_bias;
`else
  assign w_pre  = w_sum_new;
`endif

  assign {w_unused_hi, w_dout} = w_pre >>> r_k;

  assign w_we    = (r_state == ST_CLEAR) || (r_v1 && !w_flush);
  assign w_waddr = (r_state == ST_CLEAR) ? r_clr_addr : r_a1;
  assign w_wdata = (r_state == ST_CLEAR) ? '0 : r_d1;

  assign sum_mon = r_sum;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rd_q <= r_mem[r_idx];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_CLEAR;
      busy       <= 1'b1;
      r_clr_addr <= '0;
      r_win_sel  <= '0;
      r_k        <= '0;
      r_idx      <= '0;
      r_div_cnt  <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_fwd      <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_a1       <= '0;
      r_fwd_d    <= '0;
      r_sum      <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      filled     <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + c_A_ONE;
          r_win_sel  <= win_sel;
          r_k        <= w_k;
          r_idx      <= '0;
          r_div_cnt  <= '0;
          r_sum      <= '0;
          filled     <= 1'b0;
          r_v0       <= 1'b0;
          r_v1       <= 1'b0;
          r_fwd      <= 1'b0;
          if (r_clr_addr == c_A_LAST) begin
            r_state <= ST_RUN;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_flush) begin
            // Anything still in the pipeline is dropped without a dout_vld.
            r_state    <= ST_CLEAR;
            busy       <= 1'b1;
            r_clr_addr <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_fwd      <= 1'b0;
            r_sum      <= '0;
            filled     <= 1'b0;
          end else begin
            r_v0 <= 1'b0;
            if (trig) begin
              r_d0 <= din;
              if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt <= '0;
                r_v0      <= 1'b1;
              end else begin
                r_div_cnt <= r_div_cnt + 6'd1;
              end
            end

            r_v1 <= r_v0;
            if (r_v0) begin
              r_d1    <= r_d0;
              r_a1    <= r_idx;
              r_idx   <= w_idx_next;
              r_fwd   <= r_v1 && (r_a1 == r_idx);
              r_fwd_d <= r_d1;
            end

            if (r_v1) begin
              r_sum    <= w_sum_new;
              dout     <= w_dout;
              dout_vld <= 1'b1;
              if (r_a1 == w_mask) begin
                filled <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mv_filter_gate_v4.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_filter_gate_v4
// Brief    : Self-checking bench for mv_filter_gate_v4 (window 8, DW 32) with
//            one instance at decimation 1 and one at decimation 4.
// Revision : 1.0
// ============================================================================
module tb_mv_filter_gate_v4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic               trig    [2];
  logic signed [31:0] din     [2];
  logic [3:0]         wsel    [2];
  logic               restart [2];
  logic signed [31:0] dout    [2];
  logic               vld     [2];
  logic               busy    [2];
  logic               filled  [2];
  logic signed [34:0] summ    [2];

  mv_filter_gate_v4 #(.DW(32), .LOG2_WIN_MAX(3), .DIV_FACTOR(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .trig(trig[0]), .din(din[0]), .win_sel(wsel[0]),
    .restart(restart[0]), .dout(dout[0]), .dout_vld(vld[0]), .busy(busy[0]),
    .filled(filled[0]), .sum_mon(summ[0])
  );

  mv_filter_gate_v4 #(.DW(32), .LOG2_WIN_MAX(3), .DIV_FACTOR(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .trig(trig[1]), .din(din[1]), .win_sel(wsel[1]),
    .restart(restart[1]), .dout(dout[1]), .dout_vld(vld[1]), .busy(busy[1]),
    .filled(filled[1]), .sum_mon(summ[1])
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input int u, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[u%0d]: got %0d expected %0d (cycle %0d)", nm, u, act, exp, cyc);
  endtask

  // Reference model: window kept as a plain list of accepted samples,
  // decimation as a trig count modulo the ratio, latency as a due-cycle queue.
  typedef struct { int due; longint d; longint s; bit f; } ev_t;
  ev_t    m_pend [2][$];
  longint m_hist [2][$];
  int     m_busy_left [2] = '{8, 8};
  int     m_wsel [2]      = '{0, 0};
  int     m_tcnt [2]      = '{0, 0};
  int     divs [2]        = '{1, 4};
  longint e_dout [2]      = '{0, 0};
  longint e_sum [2]       = '{0, 0};
  bit     e_vld [2]       = '{0, 0};
  bit     e_f [2]         = '{0, 0};

  task automatic accept(input int u, input longint x);
    int k, n, sz;
    longint s;
    ev_t ev;
    m_hist[u].push_back(x);
    if (m_hist[u].size() > 8) void'(m_hist[u].pop_front());
    k  = (m_wsel[u] > 3) ? 3 : m_wsel[u];
    n  = 1 << k;
    sz = m_hist[u].size();
    s  = 0;
    for (int i = 0; i < n && i < sz; i++) s += m_hist[u][sz-1-i];
    ev.due = cyc + 2;
    ev.s   = s;
`ifdef MVF_ROUND_EN
    ev.d   = (k > 0) ? ((s + (64'sd1 <<< (k-1))) >>> k) : s;
`else
    ev.d   = s >>> k;
`endif
    ev.f   = (m_tcnt[u] / divs[u]) >= n;
    m_pend[u].push_back(ev);
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (!n_rst) begin
        m_busy_left[u] = 8; m_pend[u].delete(); m_hist[u].delete(); m_tcnt[u] = 0;
        m_wsel[u] = 0; e_dout[u] = 0; e_sum[u] = 0; e_vld[u] = 0; e_f[u] = 0;
      end else if (m_busy_left[u] > 0) begin
        m_busy_left[u]--; m_wsel[u] = int'(wsel[u]); e_vld[u] = 0;
      end else if (restart[u] || (int'(wsel[u]) != m_wsel[u])) begin
        m_busy_left[u] = 8; m_pend[u].delete(); m_hist[u].delete(); m_tcnt[u] = 0;
        e_vld[u] = 0; e_sum[u] = 0; e_f[u] = 0;
      end else begin
        e_vld[u] = 0;
        if (m_pend[u].size() > 0 && m_pend[u][0].due == cyc) begin
          ev_t ev;
          ev = m_pend[u].pop_front();
          e_dout[u] = ev.d; e_sum[u] = ev.s; e_vld[u] = 1;
          if (ev.f) e_f[u] = 1;
        end
        if (trig[u]) begin
          m_tcnt[u]++;
          if (m_tcnt[u] % divs[u] == 0) accept(u, longint'(din[u]));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!n_rst) begin
        chk("rst_busy", u, busy[u], 1);
        chk("rst_vld", u, vld[u], 0);
        chk("rst_dout", u, dout[u], 0);
        chk("rst_sum", u, summ[u], 0);
        chk("rst_filled", u, filled[u], 0);
      end else begin
        chk("busy", u, busy[u], longint'(m_busy_left[u] > 0));
        chk("vld", u, vld[u], e_vld[u]);
        chk("dout", u, dout[u], e_dout[u]);
        chk("sum_mon", u, summ[u], e_sum[u]);
        chk("filled", u, filled[u], e_f[u]);
      end
    end
  end

  typedef struct { int c; longint d; bit f; } out_t;
  out_t q0[$];
  out_t q1[$];

  always @(negedge clk) begin
    if (n_rst && vld[0]) q0.push_back('{cyc, longint'(dout[0]), filled[0]});
    if (n_rst && vld[1]) q1.push_back('{cyc, longint'(dout[1]), filled[1]});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic measure(input int u, output int n);
    n = 0;
    while (busy[u] && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic feed0(input longint v);
    din[0] = 32'(v); trig[0] = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    longint exp32 [5] = '{25, 50, 75, 100, 100};
    bit     f32 [5]   = '{0, 0, 0, 1, 1};
    longint exp33 [3] = '{5, -7, 9};

    trig = '{1'b1, 1'b1}; din = '{100, 0}; wsel = '{4'd2, 4'd2}; restart = '{1'b0, 1'b0};
    repeat (3) tick();

    // Clear after reset release, trig held high throughout.
    n_rst = 1'b1;
    measure(0, n);
    chk("clr_len_rst", 0, n, 8);
    chk("no_vld_in_clr", 0, q0.size(), 0);
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) trig[1] = 1'b0;
      tick();
    end
    trig[0] = 1'b0;
    repeat (5) tick();
    chk("k2_count", 0, q0.size(), 5);
    if (q0.size() == 5) begin
      chk("k2_latency", 0, q0[0].c - c0, 3);
      for (int i = 0; i < 5; i++) begin
        chk("k2_dout", 0, q0[i].d, exp32[i]);
        chk("k2_filled", 0, q0[i].f, f32[i]);
        chk("k2_back2back", 0, q0[i].c - q0[0].c, i);
      end
    end
    chk("div4_no_early_out", 1, q1.size(), 0);

    // k=0 back-to-back through the forwarding path.
    q0.delete();
    wsel[0] = 4'd0; tick();
    measure(0, n);
    chk("clr_len_k0", 0, n, 8);
    for (int i = 0; i < 3; i++) feed0(exp33[i]);
    trig[0] = 1'b0;
    repeat (4) tick();
    chk("k0_count", 0, q0.size(), 3);
    if (q0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("k0_dout", 0, q0[i].d, exp33[i]);
        chk("k0_back2back", 0, q0[i].c - q0[0].c, i);
      end
    end
    chk("k0_sum", 0, summ[0], 9);

    // Negative average with k=1.
    q0.delete();
    wsel[0] = 4'd1; tick();
    measure(0, n);
    feed0(-3);
    trig[0] = 1'b0;
    repeat (4) tick();
    chk("neg_count", 0, q0.size(), 1);
`ifdef MVF_ROUND_EN
    if (q0.size() == 1) chk("neg_dout", 0, q0[0].d, -1);
`else
    if (q0.size() == 1) chk("neg_dout", 0, q0[0].d, -2);
`endif
    chk("neg_sum", 0, summ[0], -3);

    // Window change with samples in flight: only the completed one shows.
    q0.delete();
    wsel[0] = 4'd2; tick();
    measure(0, n);
    for (int i = 0; i < 3; i++) feed0(100);
    trig[0] = 1'b0; wsel[0] = 4'd3;
    tick();
    chk("chg_busy", 0, busy[0], 1);
    chk("chg_sum_zero", 0, summ[0], 0);
    chk("chg_filled_zero", 0, filled[0], 0);
    measure(0, n);
    chk("clr_len_chg", 0, n, 8);
    chk("inflight_dropped", 0, q0.size(), 1);
    if (q0.size() == 1) chk("inflight_first", 0, q0[0].d, 25);
    q0.delete();
    feed0(64);
    trig[0] = 1'b0;
    repeat (4) tick();
    chk("k3_count", 0, q0.size(), 1);
    if (q0.size() == 1) chk("k3_dout", 0, q0[0].d, 8);

    // Decimation by 4; restart held into the clear must not extend it.
    restart[1] = 1'b1; tick(); tick();
    restart[1] = 1'b0;
    measure(1, n);
    chk("clr_len_restart", 1, n + 1, 8);
    for (int i = 1; i <= 8; i++) begin
      din[1] = 32'(10 * i); trig[1] = 1'b1; tick();
      trig[1] = 1'b0; tick();
    end
    repeat (4) tick();
    chk("div4_count", 1, q1.size(), 2);
    if (q1.size() == 2) begin
      chk("div4_first", 1, q1[0].d, 10);
      chk("div4_second", 1, q1[1].d, 30);
    end
    chk("div4_sum", 1, summ[1], 120);

    // Reset in the middle of a clear restarts it from the top.
    restart[0] = 1'b1; tick();
    restart[0] = 1'b0; tick(); tick();
    n_rst = 1'b0; tick(); tick();
    n_rst = 1'b1;
    measure(0, n);
    chk("clr_len_midrst", 0, n, 8);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
